liteic_qos_arbiter: RTL and testbench
=====================================

Name: liteic_qos_arbiter

Overview:
Parametrised N-way arbiter for interconnect slave nodes, read and write. It replaces the fixed per-node arbitration logic. It selects one requesting master per transaction using QoS (ar_qos/aw_qos), a round-robin tie-break, and optional starvation aging. The grant is held until the slave-side handshake completes. One instance sits in each slave node read path and each slave node write path.

Parameters:
NUM_REQ, 4, number of requesters (master slots), 1..32
QOS_W, 4, QoS field width per requester
MODE, 2, 0 = pure round-robin; 1 = QoS with RR tie-break; 2 = QoS with RR tie-break and aging
AGE_W, 4, width of per-requester age counter
AGE_THRESH, 8, age value at which a requester is promoted to the starved class (must be <= 2^AGE_W-1)
IDX_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), grant index width (derived)

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
req_i  in  NUM_REQ  request per master (valid of that master toward this slave)
qos_i  in  NUM_REQ*QOS_W  packed QoS; requester k occupies bits [k*QOS_W +: QOS_W]
ack_i  in  1  transaction complete for current grant (handshake done on slave side)
gnt_o  out  NUM_REQ  one-hot grant, registered
gnt_idx_o  out  IDX_W  binary index of granted requester, registered
gnt_val_o  out  1  a grant is active
starved_o  out  NUM_REQ  requester age >= AGE_THRESH (debug/perf)

Behaviour:
- Single clock clk_i. Reset is synchronous and active-low on rstn_i.
- Reset values: gnt_o=0, gnt_idx_o=0, gnt_val_o=0, starved_o=0, all age counters 0, RR pointer 0.
- Arbitration happens at a clock edge when (!gnt_val_o || ack_i) and |req_i. The winner is loaded into gnt_o, gnt_idx_o and gnt_val_o=1 at that edge. Latency from the first req_i to gnt_val_o is 1 cycle.
- Back-to-back: if ack_i and another request are present in the same cycle, the new grant loads at the same edge with no bubble. The just-finished requester may win again if the rules allow it.
- ack_i && gnt_val_o && !(|req_i): gnt_val_o, gnt_o and gnt_idx_o clear at the edge.
- ack_i while !gnt_val_o is ignored.
- The grant is held while gnt_val_o && !ack_i, even if the granted req_i drops. Deasserting a request mid-grant is a protocol error, but the arbiter stays stable.
- Effective priority per requester is {starved_k, qos_k}, QOS_W+1 bits, unsigned.
  - MODE 0: all priorities are treated as equal.
  - MODE 1: starved_k is forced to 0.
- Winner: among requesting k with maximal effective priority, pick the first index at or after the RR pointer, wrapping NUM_REQ-1 -> 0.
- RR pointer: on each grant it becomes (winner+1) mod NUM_REQ. At NUM_REQ=1 it stays 0.
- Aging (MODE 2 only; counters held at 0 otherwise):
  - At each arbitration edge, each requesting k that does not win increments its age, saturating at 2^AGE_W-1.
  - The winner's age resets to 0.
  - A non-requesting k keeps its age.
  - Ages do not change on edges without arbitration.
- starved_o[k] = (age_k >= AGE_THRESH), registered alongside the age.
- A reset asserted mid-grant clears everything at that edge. The next arbitration begins from pointer 0.

Decomposition:
- liteic_pkg gains:
  - IC_QOS_WIDTH = 4.
  - typedef enum arb_mode_e {ARB_RR, ARB_QOS, ARB_QOS_AGE}, which MODE takes.
  - IC_ARB_AGE_THRESH default.
- One combinational sub-module, liteic_rr_pick #(N): inputs are a candidate mask and the pointer; outputs are a one-hot winner and an index. It is implemented as a double-width masked priority encoder. The top block computes the max-priority mask and feeds it to liteic_rr_pick.

Test Plan:
- Reset: drive rstn_i=0 with req_i=4'b1111 -> gnt_o=0, gnt_val_o=0, starved_o=0. Release reset -> gnt_o=0001, gnt_idx_o=0 one cycle later.
- MODE 0, req_i=1111 held, ack_i pulsed every grant cycle -> gnt_idx_o sequence 0,1,2,3,0,1 with no idle cycles.
- MODE 1, req0 qos=2, req2 qos=9, req3 qos=9 held, ack each grant -> grants alternate 2,3,2,3; requester 0 is never granted.
- MODE 2, AGE_THRESH=8: req0 qos=15, req1 qos=0, both held, ack each cycle -> grants 0 ×8, then 1. starved_o[1]=1 on the cycle before that grant; age1 returns to 0 after it.
- Hold: grant to 1, then drop req_i[1] while ack_i=0 for 5 cycles -> gnt_o stays 0010. Ack with req_i=0 -> gnt_val_o=0 next cycle.
- Reset mid-grant (gnt_idx_o=2, ack_i=0) with req_i=1111 -> outputs clear at the edge. After release, the first grant is index 0.

Source files
------------

// File: rtl/liteic_pkg.sv
// Shared interconnect types and defaults.
// Used by the slave-node arbitration logic.
package liteic_pkg;

   localparam int IC_QOS_WIDTH      = 4;
   localparam int IC_ARB_AGE_THRESH = 8;

   typedef enum logic [1:0] {
      ARB_RR      = 2'd0,
      ARB_QOS     = 2'd1,
      ARB_QOS_AGE = 2'd2
   } arb_mode_e;

endpackage

// File: rtl/liteic_rr_pick.sv
// Round-robin pick: first candidate at or after the pointer, wrapping.
// Double-width masked priority encoder.
module liteic_rr_pick
   import liteic_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     cand_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     onehot_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [N-1:0]   w_mask;
   logic [2*N-1:0] w_dbl;
   logic           w_found;

   // Low half holds candidates at/after the pointer, high half the wrap
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_mask[i] = (i >= int'(ptr_i));
      end
      w_dbl    = {cand_i, cand_i & w_mask};
      w_found  = 1'b0;
      onehot_o = '0;
      idx_o    = '0;
      for (int i = 0; i < 2 * N; i++) begin
         if (!w_found && w_dbl[i]) begin
            w_found           = 1'b1;
            onehot_o[i % N]   = 1'b1;
            idx_o             = IDX_W'(i % N);
         end
      end
   end

endmodule

// File: rtl/liteic_qos_arbiter.sv
// N-way QoS arbiter with round-robin tie-break and starvation aging.
// Grant is held until the slave-side ack.
module liteic_qos_arbiter
   import liteic_pkg::*;
#(
   parameter int        NUM_REQ    = 4,
   parameter int        QOS_W      = IC_QOS_WIDTH,
   parameter arb_mode_e MODE       = ARB_QOS_AGE,
   parameter int        AGE_W      = 4,
   parameter int        AGE_THRESH = IC_ARB_AGE_THRESH,
   parameter int        IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*QOS_W-1:0] qos_i,
   input  logic                     ack_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [IDX_W-1:0]         gnt_idx_o,
   output logic                     gnt_val_o,
   output logic [NUM_REQ-1:0]       starved_o
);

   localparam int P = QOS_W + 1;
   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

   logic [NUM_REQ-1:0] r_gnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_val;
   logic [NUM_REQ-1:0] r_starved;
   logic [IDX_W-1:0]   r_ptr;
   logic [AGE_W-1:0]   r_age [NUM_REQ];

   logic [P-1:0]       w_prio [NUM_REQ];
   logic [P-1:0]       w_max;
   logic [NUM_REQ-1:0] w_cand;
   logic [NUM_REQ-1:0] w_win;
   logic [IDX_W-1:0]   w_win_idx;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [AGE_W-1:0]   w_age_nxt [NUM_REQ];
   logic               w_arb;

   assign w_arb = (!r_val || ack_i) && (|req_i);

   always_comb begin
      w_max = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         unique case (MODE)
            ARB_RR:  w_prio[k] = '0;
            ARB_QOS: w_prio[k] = {1'b0, qos_i[k*QOS_W +: QOS_W]};
            default: w_prio[k] = {r_starved[k], qos_i[k*QOS_W +: QOS_W]};
         endcase
         if (req_i[k] && (w_prio[k] > w_max)) w_max = w_prio[k];
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand[k] = req_i[k] && (w_prio[k] == w_max);
      end
   end

   liteic_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .cand_i   (w_cand),
      .ptr_i    (r_ptr),
      .onehot_o (w_win),
      .idx_o    (w_win_idx)
   );

   assign w_ptr_nxt = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                         : w_win_idx + 1'b1;

   // Losers that are still requesting age; the winner restarts from zero
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         if (MODE != ARB_QOS_AGE || w_win[k]) begin
            w_age_nxt[k] = '0;
         end else if (req_i[k] && r_age[k] != AGE_MAX) begin
            w_age_nxt[k] = r_age[k] + 1'b1;
         end else begin
            w_age_nxt[k] = r_age[k];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_gnt     <= '0;
         r_idx     <= '0;
         r_val     <= 1'b0;
         r_starved <= '0;
         r_ptr     <= '0;
         for (int k = 0; k < NUM_REQ; k++) r_age[k] <= '0;
      end else if (w_arb) begin
         r_gnt <= w_win;
         r_idx <= w_win_idx;
         r_val <= 1'b1;
         r_ptr <= w_ptr_nxt;
         for (int k = 0; k < NUM_REQ; k++) begin
            r_age[k]     <= w_age_nxt[k];
            r_starved[k] <= int'(w_age_nxt[k]) >= AGE_THRESH;
         end
      end else if (ack_i && r_val) begin
         r_gnt <= '0;
         r_idx <= '0;
         r_val <= 1'b0;
      end
   end

   assign gnt_o     = r_gnt;
   assign gnt_idx_o = r_idx;
   assign gnt_val_o = r_val;
   assign starved_o = r_starved;

endmodule

// File: tb/tb_liteic_qos_arbiter.sv
// Directed bench for liteic_qos_arbiter in all three arbitration modes.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_liteic_qos_arbiter;
   import liteic_pkg::*;

   localparam int N  = 4;
   localparam int QW = 4;
   localparam int IW = 2;

   logic          clk;
   logic          rstn;
   logic [N-1:0]  req;
   logic [N*QW-1:0] qos;
   logic          ack;

   logic [N-1:0]  gnt_rr,  gnt_q,  gnt_a;
   logic [IW-1:0] idx_rr,  idx_q,  idx_a;
   logic          val_rr,  val_q,  val_a;
   logic [N-1:0]  stv_rr,  stv_q,  stv_a;

   int n_chk = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   liteic_qos_arbiter #(.NUM_REQ(N), .QOS_W(QW), .MODE(ARB_RR)) u_rr (
      .clk_i(clk), .rstn_i(rstn), .req_i(req), .qos_i(qos), .ack_i(ack),
      .gnt_o(gnt_rr), .gnt_idx_o(idx_rr), .gnt_val_o(val_rr),
      .starved_o(stv_rr));

   liteic_qos_arbiter #(.NUM_REQ(N), .QOS_W(QW), .MODE(ARB_QOS)) u_qos (
      .clk_i(clk), .rstn_i(rstn), .req_i(req), .qos_i(qos), .ack_i(ack),
      .gnt_o(gnt_q), .gnt_idx_o(idx_q), .gnt_val_o(val_q),
      .starved_o(stv_q));

   liteic_qos_arbiter #(.NUM_REQ(N), .QOS_W(QW), .MODE(ARB_QOS_AGE),
                        .AGE_THRESH(8)) u_age (
      .clk_i(clk), .rstn_i(rstn), .req_i(req), .qos_i(qos), .ack_i(ack),
      .gnt_o(gnt_a), .gnt_idx_o(idx_a), .gnt_val_o(val_a),
      .starved_o(stv_a));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req  = '0;
      ack  = 1'b0;
      qos  = '0;
      cyc();
      cyc();
      rstn = 1'b1;
   endtask

   int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
   int q_seq  [4] = '{2, 3, 2, 3};

   initial begin
      rstn = 1'b0;
      req  = 4'b1111;
      qos  = '0;
      ack  = 1'b0;
      cyc();
      cyc();
      chk("rst_gnt",  32'(gnt_a), 32'h0);
      chk("rst_val",  32'(val_a), 32'h0);
      chk("rst_stv",  32'(stv_a), 32'h0);
      chk("rst_idx",  32'(idx_a), 32'h0);
      rstn = 1'b1;
      cyc();
      chk("rel_gnt",  32'(gnt_a), 32'h1);
      chk("rel_idx",  32'(idx_a), 32'h0);
      chk("rel_val",  32'(val_a), 32'h1);

      // round robin, ack every grant cycle
      chk("rr_0", 32'(idx_rr), 32'(rr_seq[0]));
      ack = 1'b1;
      for (int i = 1; i < 6; i++) begin
         cyc();
         chk($sformatf("rr_%0d", i), 32'(idx_rr), 32'(rr_seq[i]));
         chk($sformatf("rr_val_%0d", i), 32'(val_rr), 32'h1);
      end

      // qos with rr tie-break
      do_reset();
      req = 4'b1101;
      qos = {4'd9, 4'd9, 4'd0, 4'd2};
      ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("qos_%0d", i), 32'(idx_q), 32'(q_seq[i]));
         chk($sformatf("qos_no0_%0d", i), 32'(gnt_q[0]), 32'h0);
      end

      // aging promotes the low-qos requester after 8 losses
      do_reset();
      req = 4'b0011;
      qos = {4'd0, 4'd0, 4'd0, 4'd15};
      ack = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         chk($sformatf("age_g0_%0d", i), 32'(idx_a), 32'h0);
         if (i == 7) chk("age_stv7", 32'(stv_a[1]), 32'h0);
      end
      chk("age_stv8", 32'(stv_a[1]), 32'h1);
      cyc();
      chk("age_g1",   32'(idx_a), 32'h1);
      chk("age_clr",  32'(stv_a[1]), 32'h0);
      cyc();
      chk("age_back", 32'(idx_a), 32'h0);

      // grant held while req drops without ack
      do_reset();
      req = 4'b0010;
      cyc();
      chk("hold_g", 32'(gnt_a), 32'h2);
      req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("hold_%0d", i), 32'(gnt_a), 32'h2);
      end
      ack = 1'b1;
      cyc();
      chk("drop_val", 32'(val_a), 32'h0);
      chk("drop_gnt", 32'(gnt_a), 32'h0);
      cyc();
      chk("idle_ack", 32'(val_a), 32'h0);
      ack = 1'b0;

      // reset mid-grant
      do_reset();
      req = 4'b0100;
      cyc();
      chk("mid_idx", 32'(idx_a), 32'h2);
      req  = 4'b1111;
      rstn = 1'b0;
      cyc();
      chk("mid_val", 32'(val_a), 32'h0);
      chk("mid_gnt", 32'(gnt_a), 32'h0);
      chk("mid_idx0", 32'(idx_a), 32'h0);
      rstn = 1'b1;
      cyc();
      chk("mid_first", 32'(idx_a), 32'h0);
      chk("mid_fval",  32'(val_a), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
